doodle_ctrl: RTL and testbench



---
 rtl/doodle_pkg.sv | 23 ++
 rtl/doodle_debounce.sv | 49 ++++
 rtl/doodle_ctrl.sv | 116 +++++++++++
 tb/tb_doodle_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/doodle_pkg.sv
// doodle_pkg: shared encodings for the doodle game handshake controller.
`default_nettype none

package doodle_pkg;

  localparam logic [3:0] G_I    = 4'b0001;
  localparam logic [3:0] G_UP   = 4'b0010;
  localparam logic [3:0] G_DOWN = 4'b0100;
  localparam logic [3:0] G_DONE = 4'b1000;

  localparam int SCORE_W_DEF = 16;

  typedef enum logic [4:0] {
    C_IDLE   = 5'b00001,
    C_LAUNCH = 5'b00010,
    C_PLAY   = 5'b00100,
    C_OVER   = 5'b01000,
    C_ACK    = 5'b10000
  } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/doodle_debounce.sv
// doodle_debounce: 2-flop synchroniser, stability counter and one-cycle rising-edge pulse.
`default_nettype none

module doodle_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic Btn_raw,
  output logic Btn_level,
  output logic Btn_pulse
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_1;
  logic             sync_2;
  logic             level_prev;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      sync_1     <= 1'b0;
      sync_2     <= 1'b0;
      Btn_level  <= 1'b0;
      level_prev <= 1'b0;
      Btn_pulse  <= 1'b0;
      cnt        <= '0;
    end else begin
      sync_1     <= Btn_raw;
      sync_2     <= sync_1;
      level_prev <= Btn_level;
      Btn_pulse  <= Btn_level & ~level_prev;
      // Any return to the accepted level restarts the stability window.
      if (sync_2 == Btn_level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        Btn_level <= sync_2;
        cnt       <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/doodle_ctrl.sv
// doodle_ctrl: Start/Ack initiator for the doodle game state machine, with score bookkeeping.
`default_nettype none

module doodle_ctrl
  import doodle_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES  = 500000,
  parameter int DONE_HOLD_CYCLES = 200000000,
  parameter bit AUTO_ACK         = 1'b1,
  parameter int SCORE_W          = SCORE_W_DEF
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               BtnC,
  input  logic [SCORE_W-1:0] Score_in,
  input  logic               q_I,
  input  logic               q_Up,
  input  logic               q_Down,
  input  logic               q_Done,
  output logic               Start,
  output logic               Ack,
  output logic [SCORE_W-1:0] Last_Score,
  output logic [SCORE_W-1:0] High_Score,
  output logic [7:0]         Games_Played,
  output logic               Sm_Err,
  output logic               q_CIdle,
  output logic               q_CLaunch,
  output logic               q_CPlay,
  output logic               q_COver,
  output logic               q_CAck
);

  localparam int HOLD_W = (DONE_HOLD_CYCLES > 1) ? $clog2(DONE_HOLD_CYCLES) : 1;
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(DONE_HOLD_CYCLES - 1);

  ctrl_state_t       state;
  ctrl_state_t       state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic              hold_done;
  logic              btn_level;
  logic              btn_pulse;
  logic              q_onehot;
  logic [3:0]        q_vec;

  doodle_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .Clk      (Clk),
    .Reset    (Reset),
    .Btn_raw  (BtnC),
    .Btn_level(btn_level),
    .Btn_pulse(btn_pulse)
  );

  assign q_vec     = {q_Done, q_Down, q_Up, q_I};
  assign hold_done = AUTO_ACK && (hold_cnt == HOLD_LAST);

  // Exact 4-state match, so X/Z vectors fall to the default and flag an error.
  always_comb begin
    q_onehot = 1'b0;
    case (q_vec)
      G_I, G_UP, G_DOWN, G_DONE: q_onehot = 1'b1;
      default:                   q_onehot = 1'b0;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) state <= C_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      C_IDLE: begin
        if (q_Done)                state_nxt = C_ACK;
        else if (btn_pulse && q_I) state_nxt = C_LAUNCH;
      end
      C_LAUNCH: if (!q_I)                    state_nxt = C_PLAY;
      C_PLAY:   if (q_Done)                  state_nxt = C_OVER;
      C_OVER:   if (btn_pulse || hold_done)  state_nxt = C_ACK;
      C_ACK:    if (q_I)                     state_nxt = C_IDLE;
      default:                               state_nxt = C_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      hold_cnt     <= '0;
      Last_Score   <= '0;
      High_Score   <= '0;
      Games_Played <= '0;
      Sm_Err       <= 1'b0;
    end else begin
      if (state == C_OVER && state_nxt == C_OVER) hold_cnt <= hold_cnt + 1'b1;
      else                                        hold_cnt <= '0;
      if (!q_onehot) Sm_Err <= 1'b1;
      if (state == C_PLAY && q_Done) begin
        Last_Score <= Score_in;
        if (Score_in > High_Score) High_Score <= Score_in;
        if (Games_Played != 8'hFF) Games_Played <= Games_Played + 8'd1;
      end
    end
  end

  assign Start     = (state == C_LAUNCH);
  assign Ack       = (state == C_ACK);
  assign q_CIdle   = (state == C_IDLE);
  assign q_CLaunch = (state == C_LAUNCH);
  assign q_CPlay   = (state == C_PLAY);
  assign q_COver   = (state == C_OVER);
  assign q_CAck    = (state == C_ACK);

endmodule

`default_nettype wire

// File: tb/tb_doodle_ctrl.sv
// tb_doodle_ctrl: directed sequence with a game-over scoreboard for doodle_ctrl.
`default_nettype none

module tb_doodle_ctrl;

  logic        Clk = 1'b0;
  logic        Reset = 1'b0;
  logic        BtnC = 1'b0;
  logic [15:0] Score_in = '0;
  logic        q_I = 1'b1, q_Up = 1'b0, q_Down = 1'b0, q_Done = 1'b0;
  logic        Start, Ack, Sm_Err;
  logic [15:0] Last_Score, High_Score;
  logic [7:0]  Games_Played;
  logic        q_CIdle, q_CLaunch, q_CPlay, q_COver, q_CAck;

  typedef struct packed {
    logic [15:0] last;
    logic [15:0] high;
    logic [7:0]  games;
  } over_t;

  over_t exp_q[$];
  int    checks = 0;
  int    errors = 0;
  int    pulses = 0;
  logic  over_d = 1'b0;
  int    model_high = 0;
  int    model_games = 0;

  doodle_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .DONE_HOLD_CYCLES(10),
    .AUTO_ACK        (1'b1),
    .SCORE_W         (16)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .BtnC        (BtnC),
    .Score_in    (Score_in),
    .q_I         (q_I),
    .q_Up        (q_Up),
    .q_Down      (q_Down),
    .q_Done      (q_Done),
    .Start       (Start),
    .Ack         (Ack),
    .Last_Score  (Last_Score),
    .High_Score  (High_Score),
    .Games_Played(Games_Played),
    .Sm_Err      (Sm_Err),
    .q_CIdle     (q_CIdle),
    .q_CLaunch   (q_CLaunch),
    .q_CPlay     (q_CPlay),
    .q_COver     (q_COver),
    .q_CAck      (q_CAck)
  );

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pop one expected record each time the controller enters game-over.
  always @(negedge Clk) begin
    if (dut.u_deb.Btn_pulse === 1'b1) pulses++;
    if (Reset && q_COver && !over_d) begin
      over_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL sb_unexpected_over: observed entry expected none");
      end else begin
        e = exp_q.pop_front();
        assert ({Last_Score, High_Score, Games_Played} === e) else begin
          errors++;
          $error("FAIL sb_over: observed last=%0d high=%0d games=%0d expected last=%0d high=%0d games=%0d",
                 Last_Score, High_Score, Games_Played, e.last, e.high, e.games);
        end
      end
    end
    over_d = q_COver;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge Clk);
    #1;
  endtask

  task automatic set_q(input logic [3:0] v);
    {q_Done, q_Down, q_Up, q_I} = v;
  endtask

  task automatic push_over(input logic [15:0] score);
    over_t e;
    if (model_games < 255) model_games++;
    if (score > model_high) model_high = score;
    e.last  = score;
    e.high  = 16'(model_high);
    e.games = 8'(model_games);
    exp_q.push_back(e);
  endtask

  task automatic press_to_play();
    BtnC = 1'b1;
    tick(8);
    check("start_after_press", Start, 1);
    BtnC = 1'b0;
    set_q(4'b0010);
    tick(1);
    check("play_entered", q_CPlay, 1);
    tick(7);
  endtask

  // Full game ending on the automatic Ack; optional press inside play must be discarded.
  task automatic play_game(input logic [15:0] score, input bit press_in_play);
    press_to_play();
    if (press_in_play) begin
      BtnC = 1'b1;
      tick(8);
      BtnC = 1'b0;
      check("play_press_discarded", q_CPlay, 1);
      tick(7);
    end
    Score_in = score;
    set_q(4'b1000);
    push_over(score);
    tick(1);
    check("over_entered", q_COver, 1);
    tick(9);
    check("ack_before_timeout", Ack, 0);
    tick(1);
    check("ack_at_timeout", Ack, 1);
    set_q(4'b0001);
    tick(1);
    check("idle_after_ack", q_CIdle, 1);
  endtask

  initial begin
    int base;
    set_q(4'b0001);
    Reset = 1'b0;
    tick(2);
    Reset = 1'b1;
    check("rst_cstate", {q_CAck, q_COver, q_CPlay, q_CLaunch, q_CIdle}, 5'b00001);
    check("rst_start_ack", {Start, Ack}, 2'b00);
    check("rst_scores", {Last_Score, High_Score, Games_Played}, 40'd0);
    check("rst_sm_err", Sm_Err, 0);

    // Three-cycle glitch stays below the stability window.
    base = pulses;
    BtnC = 1'b1;
    tick(3);
    BtnC = 1'b0;
    tick(8);
    check("glitch_no_pulse", pulses - base, 0);
    check("glitch_idle", q_CIdle, 1);

    // Clean press: pulse after 2+4+1 edges, Start on the following edge.
    base = pulses;
    BtnC = 1'b1;
    tick(7);
    check("pulse_latency", dut.u_deb.Btn_pulse, 1);
    check("start_not_yet", Start, 0);
    tick(1);
    check("start_rise", Start, 1);
    BtnC = 1'b0;
    tick(3);
    check("start_hold", Start, 1);
    check("one_pulse", pulses - base, 1);
    set_q(4'b0010);
    tick(1);
    check("start_drop", Start, 0);
    check("play_state", q_CPlay, 1);
    tick(5);

    // Game 1: automatic Ack on cycle 10 of game-over.
    Score_in = 16'd37;
    set_q(4'b1000);
    push_over(16'd37);
    tick(1);
    check("g1_over", q_COver, 1);
    tick(9);
    check("g1_ack_early", Ack, 0);
    tick(1);
    check("g1_ack", Ack, 1);
    check("g1_no_start", Start, 0);
    set_q(4'b0001);
    tick(1);
    check("g1_ack_drop", Ack, 0);
    check("g1_idle", q_CIdle, 1);
    tick(8);

    // Game 2: lower score, button press acknowledges ahead of the timeout.
    press_to_play();
    BtnC = 1'b1;
    tick(4);
    Score_in = 16'd20;
    set_q(4'b1000);
    push_over(16'd20);
    tick(1);
    check("g2_over", q_COver, 1);
    tick(2);
    check("g2_no_ack_yet", Ack, 0);
    tick(1);
    check("g2_btn_ack", Ack, 1);
    BtnC = 1'b0;
    set_q(4'b0001);
    tick(1);
    check("g2_idle", q_CIdle, 1);
    check("g2_high_kept", High_Score, 37);

    // Non-one-hot vector is sticky until reset.
    set_q(4'b0110);
    tick(1);
    check("sm_err_set", Sm_Err, 1);
    set_q(4'b0001);
    tick(2);
    check("sm_err_sticky", Sm_Err, 1);
    check("sm_err_no_effect", q_CIdle, 1);
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    model_high = 0;
    model_games = 0;
    check("sm_err_cleared", Sm_Err, 0);
    check("games_cleared", Games_Played, 0);
    tick(8);

    // 256 games to reach saturation; first one also tests a discarded press in play.
    for (int g = 0; g < 256; g++) begin
      play_game(16'($urandom_range(0, 1000)), g == 0);
      tick(1);
    end
    check("games_saturated", Games_Played, 255);
    check("high_model", High_Score, model_high);

    // Reset mid-game, then a leftover DONE forces Ack without latching a score.
    press_to_play();
    set_q(4'b0100);
    Score_in = 16'd999;
    Reset = 1'b0;
    tick(1);
    Reset = 1'b1;
    check("midgame_rst_idle", q_CIdle, 1);
    set_q(4'b1000);
    tick(1);
    check("recovery_ack", Ack, 1);
    check("recovery_no_latch", {Last_Score, Games_Played}, 24'd0);
    set_q(4'b0001);
    tick(1);
    check("recovery_idle", q_CIdle, 1);

    check("sb_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
